// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, next-PC select encoding and PC increment helper for the MIPS core
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] IRQ_VECTOR_DEF = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0008;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

    // Next-PC source, listed lowest to highest priority
    typedef enum logic [1:0] {
        SEQ   = 2'd0,
        REDIR = 2'd1,
        IRQ   = 2'd2,
        EXC   = 2'd3
    } npc_sel_e;

    // Bit 31 marks kernel space and must survive sequential fetch, so only
    // the low 31 bits increment and wrap.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch stage bus: pipeline controls, instruction memory port and IF/ID outputs
// Signals:
//   stall, flush, redirect, redirect_target, exc_req, irq_req : pipeline -> fetch
//   imem_addr : fetch -> instruction memory, imem_data : memory -> fetch
//   ifid_instr, ifid_pc_plus4, ifid_pc, ifid_valid : fetch -> decode
// Modports: master = pipeline/memory side, slave = if_stage.
interface if_stage_if;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        exc_req;
    logic        irq_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_pc;
    logic        ifid_valid;

    modport master (
        output stall, flush, redirect, redirect_target, exc_req, irq_req, imem_data,
        input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_pc, ifid_valid
    );

    modport slave (
        input  stall, flush, redirect, redirect_target, exc_req, irq_req, imem_data,
        output imem_addr, ifid_instr, ifid_pc_plus4, ifid_pc, ifid_valid
    );
endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and flush-to-bubble controls
// Ports:
//   clk, reset (async active-low)
//   i_hold  : keep current contents
//   i_flush : load a bubble (NOP, valid=0) but still record PC/PC+4; beats i_hold
//   i_instr, i_pc, i_pc_plus4 : fetched instruction and its addresses
//   o_instr, o_pc, o_pc_plus4, o_valid : registered outputs
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_hold,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_instr    <= NOP_WORD;
            o_pc       <= 32'h0;
            o_pc_plus4 <= 32'h0;
            o_valid    <= 1'b0;
        end else if (i_flush) begin
            // PC of the squashed slot is kept so an exception taken here has an EPC
            o_instr    <= NOP_WORD;
            o_pc       <= i_pc;
            o_pc_plus4 <= i_pc_plus4;
            o_valid    <= 1'b0;
        end else if (!i_hold) begin
            o_instr    <= i_instr;
            o_pc       <= i_pc;
            o_pc_plus4 <= i_pc_plus4;
            o_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS fetch stage: PC register, next-PC selection and IF/ID capture
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : if_stage_if.slave (controls in, imem port, IF/ID outputs)
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] IRQ_VECTOR = IRQ_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.slave   bus
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_take_irq;
    logic        w_squash;
    npc_sel_e    w_sel;

    assign bus.imem_addr = r_pc;
    assign w_pc_plus4    = pc_plus4(r_pc);

    // Interrupts are masked while executing in kernel space
    assign w_take_irq = bus.irq_req && !r_pc[31];

    always_comb begin
        w_sel = SEQ;
        if (bus.exc_req) begin
            w_sel = EXC;
        end else if (w_take_irq) begin
            w_sel = IRQ;
        end else if (bus.redirect) begin
            w_sel = REDIR;
        end
    end

    // Vectors and redirects override a stall; only the sequential path holds
    always_comb begin
        w_next_pc = r_pc;
        case (w_sel)
            EXC:   w_next_pc = EXC_VECTOR;
            IRQ:   w_next_pc = IRQ_VECTOR;
            REDIR: w_next_pc = {bus.redirect_target[31:2], 2'b00};
            SEQ:   w_next_pc = bus.stall ? r_pc : w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // Any control-flow change squashes the instruction fetched this cycle
    assign w_squash = bus.flush || (w_sel != SEQ);

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .i_hold     (bus.stall),
        .i_flush    (w_squash),
        .i_instr    (bus.imem_data),
        .i_pc       (r_pc),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (bus.ifid_instr),
        .o_pc       (bus.ifid_pc),
        .o_pc_plus4 (bus.ifid_pc_plus4),
        .o_valid    (bus.ifid_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking testbench for if_stage
module tb_if_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    if_stage_if bus();

    if_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2010_0000;
            32'h0000_0004: return 32'h2002_0014;
            default:       return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    assign bus.imem_data = imem_fn(bus.imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] ip4;
        logic        valid;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc, m_instr, m_ipc, m_ip4;
    logic        m_valid;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_ip4 = 32'h0; m_valid = 1'b0;
        sb_q.delete();
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.flush = 0; bus.redirect = 0; bus.redirect_target = 32'h0;
        bus.exc_req = 0; bus.irq_req = 0;
    endtask

    // Reference model advance for one edge; expectation queued, then the edge is taken
    task automatic step();
        logic [31:0] p4, npc;
        logic take_irq, squash;
        exp_t e;
        p4 = {m_pc[31], m_pc[30:0] + 31'd4};
        take_irq = bus.irq_req && (m_pc[31] == 1'b0);
        squash = bus.flush || bus.exc_req || take_irq || bus.redirect;
        if (bus.exc_req)       npc = 32'h8000_0008;
        else if (take_irq)     npc = 32'h8000_0004;
        else if (bus.redirect) npc = bus.redirect_target & 32'hFFFF_FFFC;
        else if (bus.stall)    npc = m_pc;
        else                   npc = p4;
        if (squash) begin
            m_instr = 32'h0; m_ipc = m_pc; m_ip4 = p4; m_valid = 1'b0;
        end else if (!bus.stall) begin
            m_instr = imem_fn(m_pc); m_ipc = m_pc; m_ip4 = p4; m_valid = 1'b1;
        end
        m_pc = npc;
        e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.ip4 = m_ip4; e.valid = m_valid;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compares each queued expectation one step after its edge
    always @(posedge clk) begin : sb_monitor
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.imem_addr !== e.pc) begin
                failures++;
                $display("FAIL sb_pc t=%0t got=%h exp=%h", $time, bus.imem_addr, e.pc);
            end
            checks++;
            if (bus.ifid_instr !== e.instr) begin
                failures++;
                $display("FAIL sb_instr t=%0t got=%h exp=%h", $time, bus.ifid_instr, e.instr);
            end
            checks++;
            if (bus.ifid_pc !== e.ipc) begin
                failures++;
                $display("FAIL sb_ifid_pc t=%0t got=%h exp=%h", $time, bus.ifid_pc, e.ipc);
            end
            checks++;
            if (bus.ifid_pc_plus4 !== e.ip4) begin
                failures++;
                $display("FAIL sb_ifid_pc_plus4 t=%0t got=%h exp=%h", $time, bus.ifid_pc_plus4, e.ip4);
            end
            checks++;
            if (bus.ifid_valid !== e.valid) begin
                failures++;
                $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, bus.ifid_valid, e.valid);
            end
        end
    end

    task automatic test_reset();
        clear_inputs();
        model_reset();
        reset = 1'b0;
        #12;
        checks++;
        if (bus.imem_addr !== 32'h0 || bus.ifid_instr !== 32'h0 || bus.ifid_pc !== 32'h0 ||
            bus.ifid_pc_plus4 !== 32'h0 || bus.ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got pc=%h instr=%h ipc=%h ip4=%h v=%b exp all zero",
                     bus.imem_addr, bus.ifid_instr, bus.ifid_pc, bus.ifid_pc_plus4, bus.ifid_valid);
        end
        reset = 1'b1;
    endtask

    task automatic test_seq();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.imem_addr !== 32'(i * 4)) begin
                failures++;
                $display("FAIL seq_addr%0d got=%h exp=%h", i, bus.imem_addr, 32'(i * 4));
            end
            step();
            if (i == 0) begin
                checks++;
                if (bus.ifid_instr !== 32'h2010_0000 || bus.ifid_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL seq_first got=%h v=%b exp=20100000 v=1", bus.ifid_instr, bus.ifid_valid);
                end
            end else if (i == 1) begin
                checks++;
                if (bus.ifid_instr !== 32'h2002_0014) begin
                    failures++;
                    $display("FAIL seq_second got=%h exp=20020014", bus.ifid_instr);
                end
            end
        end
    endtask

    task automatic test_stall();
        bus.stall = 1;
        repeat (3) step();
        checks++;
        if (bus.imem_addr !== 32'h10 || bus.ifid_pc !== 32'hC) begin
            failures++;
            $display("FAIL stall_hold got pc=%h ipc=%h exp pc=10 ipc=c", bus.imem_addr, bus.ifid_pc);
        end
        bus.stall = 0;
        step();
        checks++;
        if (bus.imem_addr !== 32'h14 || bus.ifid_pc !== 32'h10) begin
            failures++;
            $display("FAIL stall_release got pc=%h ipc=%h exp pc=14 ipc=10", bus.imem_addr, bus.ifid_pc);
        end
    endtask

    task automatic test_redirect();
        repeat (3) step();
        checks++;
        if (bus.imem_addr !== 32'h20) begin
            failures++;
            $display("FAIL redir_setup got=%h exp=20", bus.imem_addr);
        end
        bus.redirect = 1; bus.redirect_target = 32'h0040_0208;
        step();
        bus.redirect = 0;
        checks++;
        if (bus.imem_addr !== 32'h0040_0208 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'h0) begin
            failures++;
            $display("FAIL redir_bubble got pc=%h v=%b instr=%h exp pc=00400208 v=0 instr=0",
                     bus.imem_addr, bus.ifid_valid, bus.ifid_instr);
        end
        step();
        checks++;
        if (bus.ifid_pc !== 32'h0040_0208 || bus.ifid_valid !== 1'b1) begin
            failures++;
            $display("FAIL redir_target got ipc=%h v=%b exp ipc=00400208 v=1", bus.ifid_pc, bus.ifid_valid);
        end
    endtask

    task automatic test_redirect_stall();
        bus.stall = 1; bus.redirect = 1; bus.redirect_target = 32'h103;
        step();
        clear_inputs();
        checks++;
        if (bus.imem_addr !== 32'h100 || bus.ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_stall got pc=%h v=%b exp pc=100 v=0", bus.imem_addr, bus.ifid_valid);
        end
    endtask

    task automatic test_flush_stall();
        bus.flush = 1; bus.stall = 1;
        step();
        clear_inputs();
        checks++;
        if (bus.imem_addr !== 32'h100 || bus.ifid_valid !== 1'b0 || bus.ifid_pc !== 32'h100) begin
            failures++;
            $display("FAIL flush_stall got pc=%h v=%b ipc=%h exp pc=100 v=0 ipc=100",
                     bus.imem_addr, bus.ifid_valid, bus.ifid_pc);
        end
    endtask

    task automatic test_irq();
        bus.redirect = 1; bus.redirect_target = 32'h40;
        step();
        bus.redirect = 0;
        bus.irq_req = 1;
        step();
        checks++;
        if (bus.imem_addr !== 32'h8000_0004 || bus.ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL irq_taken got pc=%h v=%b exp pc=80000004 v=0", bus.imem_addr, bus.ifid_valid);
        end
        step();
        checks++;
        if (bus.imem_addr !== 32'h8000_0008 || bus.ifid_valid !== 1'b1) begin
            failures++;
            $display("FAIL irq_masked got pc=%h v=%b exp pc=80000008 v=1", bus.imem_addr, bus.ifid_valid);
        end
        bus.irq_req = 0;
    endtask

    task automatic test_wrap();
        bus.redirect = 1; bus.redirect_target = 32'hFFFF_FFFF;
        step();
        bus.redirect = 0;
        step();
        checks++;
        if (bus.imem_addr !== 32'h8000_0000 || bus.ifid_pc !== 32'hFFFF_FFFC ||
            bus.ifid_pc_plus4 !== 32'h8000_0000) begin
            failures++;
            $display("FAIL wrap got pc=%h ipc=%h ip4=%h exp pc=80000000 ipc=fffffffc ip4=80000000",
                     bus.imem_addr, bus.ifid_pc, bus.ifid_pc_plus4);
        end
    endtask

    task automatic test_exc();
        bus.redirect = 1; bus.redirect_target = 32'h50;
        step();
        bus.redirect = 0;
        bus.exc_req = 1; bus.irq_req = 1;
        step();
        bus.exc_req = 0;
        checks++;
        if (bus.imem_addr !== 32'h8000_0008 || bus.ifid_valid !== 1'b0 || bus.ifid_pc !== 32'h50) begin
            failures++;
            $display("FAIL exc_prio got pc=%h v=%b ipc=%h exp pc=80000008 v=0 ipc=50",
                     bus.imem_addr, bus.ifid_valid, bus.ifid_pc);
        end
        step();
        checks++;
        if (bus.imem_addr !== 32'h8000_000C) begin
            failures++;
            $display("FAIL exc_irq_masked got=%h exp=8000000c", bus.imem_addr);
        end
        bus.irq_req = 0;
    endtask

    task automatic test_async_reset();
        bus.stall = 1; bus.redirect = 1; bus.redirect_target = 32'h300;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.imem_addr !== 32'h0 || bus.ifid_instr !== 32'h0 || bus.ifid_pc !== 32'h0 ||
            bus.ifid_pc_plus4 !== 32'h0 || bus.ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got pc=%h instr=%h ipc=%h ip4=%h v=%b exp all zero",
                     bus.imem_addr, bus.ifid_instr, bus.ifid_pc, bus.ifid_pc_plus4, bus.ifid_valid);
        end
        model_reset();
        clear_inputs();
        #3;
        reset = 1'b1;
        step();
        checks++;
        if (bus.imem_addr !== 32'h4 || bus.ifid_instr !== 32'h2010_0000 || bus.ifid_valid !== 1'b1) begin
            failures++;
            $display("FAIL post_reset got pc=%h instr=%h v=%b exp pc=4 instr=20100000 v=1",
                     bus.imem_addr, bus.ifid_instr, bus.ifid_valid);
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_flush_stall();
        test_irq();
        test_wrap();
        test_exc();
        test_async_reset();
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Fetch stage of the pipelined MIPS core.
- Owns the PC register and next-PC selection, drives the fetch address into the combinational instruction memory, and captures the returned instruction word into the IF/ID pipeline register.
- Handles hazard-unit stalls, control-hazard flushes, branch/jump/jr redirects and exception/interrupt vectoring.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IRQ_VECTOR, 32'h80000004, interrupt handler entry (kernel space).
- EXC_VECTOR, 32'h80000008, exception handler entry (kernel space).
- NOP_WORD, 32'h00000000, bubble inserted into IF/ID on flush.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  replace the IF/ID contents with a bubble this edge.
- redirect  in  1  branch taken / j / jal / jr resolved downstream.
- redirect_target  in  32  target address for redirect.
- exc_req  in  1  synchronous exception request (undefined op etc.).
- irq_req  in  1  external interrupt request, level.
- imem_addr  out  32  fetch address to instruction memory (= PC).
- imem_data  in  32  instruction returned combinationally for imem_addr.
- ifid_instr  out  32  registered instruction.
- ifid_pc_plus4  out  32  registered PC+4 of that instruction (link value / branch base).
- ifid_pc  out  32  registered PC of that instruction (EPC source).
- ifid_valid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (reset=0, async):
  - PC=RESET_PC, ifid_instr=NOP_WORD, ifid_pc=0, ifid_pc_plus4=0, ifid_valid=0.
  - First valid fetch is captured on the first rising edge after reset deasserts.
- imem_addr = PC, combinational; imem_data is expected in the same cycle (zero-latency memory).
- pc_plus4 = {PC[31], PC[30:0]+4}: bit 31 (kernel bit) is preserved; the low 31 bits wrap modulo 2^31.
- Next-PC priority, highest first:
  1. exc_req -> EXC_VECTOR.
  2. irq_req and PC[31]==0 -> IRQ_VECTOR. Interrupts are masked in kernel mode.
  3. redirect -> {redirect_target[31:2], 2'b00}. Low bits are forced to zero.
  4. stall -> PC unchanged.
  5. otherwise -> pc_plus4.
- Items 1-3 override stall: a redirect or vector during a stall still updates the PC.
- IF/ID update, evaluated each edge, highest priority first:
  - flush, or any of exc_req / taken irq / redirect: load NOP_WORD, valid=0, ifid_pc=PC, ifid_pc_plus4=pc_plus4. The wrong-path instruction is squashed.
  - stall: hold all IF/ID outputs.
  - otherwise: load imem_data, PC, pc_plus4, valid=1.
- Simultaneous flush and stall: flush wins.
- Simultaneous exc_req and irq_req: the exception is taken; irq stays pending as a level and is taken later if still asserted.
- Exactly one PC update per edge; no multi-cycle states. Redirect penalty is 1 bubble, counted from redirect assertion.
- Reset asserted mid-stall or mid-redirect: reset values apply immediately; all pending requests are discarded.

Decomposition:
- Shared package (mips_pkg):
  - RESET_PC, IRQ_VECTOR and EXC_VECTOR defaults.
  - NOP_WORD.
  - 2-bit next-PC select encoding: SEQ, REDIR, IRQ, EXC.
- One natural sub-module, if_id_reg: the IF/ID register with hold/flush controls and the async active-low reset. The PC register and next-PC mux stay in if_stage.

Test Plan:
- Reset, then 4 free-running edges:
  - imem_addr steps 0x0, 0x4, 0x8, 0xC.
  - ifid_instr follows imem_data one edge later (e.g. 0x20100000, then 0x20020014).
  - ifid_valid rises after the first edge.
- PC=0x10 with stall=1 for 3 edges:
  - PC holds 0x10; IF/ID holds its prior contents.
  - After release: PC -> 0x14, ifid_pc=0x10.
- redirect=1, target=0x00400208, at PC=0x20:
  - Next edge: PC=0x00400208, ifid_valid=0, ifid_instr=0.
  - Following edge: ifid_pc=0x00400208, valid=1.
- redirect with stall=1 and target=0x103: PC becomes 0x100; IF/ID is a bubble.
- irq_req=1 at PC=0x40: PC -> 0x80000004. irq_req held at PC=0x80000004: PC -> 0x80000008, i.e. masked.
- exc_req and irq_req together at PC=0x50: PC -> 0x80000008. Then assert reset mid-stream: all outputs return to reset values asynchronously, before the next edge.
